// File: rtl/gate_model_bist.sv
// Built-in self-test controller for combinational gate models.
// An LFSR drives the CUT inputs from a flop, and a MISR compacts one CUT response per clock.
// After PAT_CNT patterns the signature is compared against golden_sig.
module gate_model_bist #(
    parameter int unsigned      IN_W      = 20,
    parameter int unsigned      OUT_W     = 10,
    parameter int unsigned      PAT_CNT   = 1024,
    parameter logic [IN_W-1:0]  LFSR_TAPS = IN_W'(20'h90000),
    parameter logic [OUT_W-1:0] MISR_TAPS = OUT_W'(10'h240),
    parameter logic [IN_W-1:0]  LFSR_SEED = IN_W'(1),
    parameter logic [OUT_W-1:0] MISR_SEED = OUT_W'(0),
    localparam int unsigned     CNT_W     = $clog2(PAT_CNT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             hold,
    input  logic [OUT_W-1:0] golden_sig,
    input  logic [OUT_W-1:0] cut_out,
    output logic [IN_W-1:0]  cut_in,
    output logic [CNT_W-1:0] pat_idx,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [OUT_W-1:0] signature
);

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [IN_W-1:0]  SEED_EFF = (LFSR_SEED == '0) ? IN_W'(1) : LFSR_SEED;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAT_CNT);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [IN_W-1:0]  lfsr_q;
    logic [OUT_W-1:0] misr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;

    logic [IN_W-1:0]  lfsr_next;
    logic [OUT_W-1:0] misr_next;
    logic [CNT_W-1:0] cnt_inc;

    // Next-step values of the pattern generator, compactor and pattern counter.
    always_comb begin
        lfsr_next = {lfsr_q[IN_W-2:0], ^(lfsr_q & LFSR_TAPS)};
        misr_next = {misr_q[OUT_W-2:0], ^(misr_q & MISR_TAPS)} ^ cut_out;
        cnt_inc   = cnt_q + CNT_W'(1);
    end

    // Control FSM with registered status flags; abort outranks start and hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            lfsr_q <= SEED_EFF;
            misr_q <= MISR_SEED;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else if (abort) begin
            state  <= IDLE;
            lfsr_q <= SEED_EFF;
            misr_q <= MISR_SEED;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state  <= RUN;
                        lfsr_q <= SEED_EFF;
                        misr_q <= MISR_SEED;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                        pass_q <= 1'b0;
                    end
                end
                RUN: begin
                    // The response to the pattern on cut_in is captured on this edge.
                    if (!hold) begin
                        lfsr_q <= lfsr_next;
                        misr_q <= misr_next;
                        cnt_q  <= cnt_inc;
                        if (cnt_inc == CNT_LAST) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            pass_q <= (misr_next == golden_sig);
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign cut_in    = lfsr_q;
    assign signature = misr_q;
    assign pat_idx   = cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;

endmodule

// File: tb/tb_gate_model_bist.sv
// Self-checking bench for gate_model_bist on a 4-bit configuration.
// A second instance with PAT_CNT=14 and a zero LFSR seed covers the short run and seed replacement.
module tb_gate_model_bist;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       hold;
    logic [3:0] golden;
    logic [3:0] cut_in, cut_out, signature, pat_idx;
    logic       busy, done, pass;
    logic [3:0] cut_in2, signature2, pat_idx2;
    logic       busy2, done2, pass2;

    int         mode;       // 0: loopback, 1: stuck-at-0, 2: random table CUT
    logic [3:0] cut_tab [16];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign cut_out = (mode == 0) ? cut_in : (mode == 1) ? 4'h0 : cut_tab[cut_in];

    gate_model_bist #(
        .IN_W(4), .OUT_W(4), .PAT_CNT(15),
        .LFSR_TAPS(4'hC), .MISR_TAPS(4'hC), .LFSR_SEED(4'h1), .MISR_SEED(4'h0)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .hold(hold),
        .golden_sig(golden), .cut_out(cut_out), .cut_in(cut_in), .pat_idx(pat_idx),
        .busy(busy), .done(done), .pass(pass), .signature(signature)
    );

    gate_model_bist #(
        .IN_W(4), .OUT_W(4), .PAT_CNT(14),
        .LFSR_TAPS(4'hC), .MISR_TAPS(4'hC), .LFSR_SEED(4'h0), .MISR_SEED(4'h0)
    ) dut2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .hold(hold),
        .golden_sig(golden), .cut_out(cut_in2), .cut_in(cut_in2), .pat_idx(pat_idx2),
        .busy(busy2), .done(done2), .pass(pass2), .signature(signature2)
    );

    typedef struct {
        int         md;
        logic [3:0] gold;
        logic [3:0] exp_sig;
        logic       exp_pass;
    } run_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Counts edges after the start edge until done rises, bounded.
    task automatic wait_done(output int edges);
        edges = 0;
        while (!done && edges < 100) begin
            step();
            edges++;
        end
    endtask

    function automatic logic [3:0] resp(input int md, input logic [3:0] p);
        if (md == 0) return p;
        if (md == 1) return 4'h0;
        return cut_tab[p];
    endfunction

    // Reference: list the x^4+x^3+1 sequence from seed 1, then fold the responses into the MISR.
    function automatic logic [3:0] model_sig(input int n, input int md);
        logic [3:0] pats[$];
        logic [3:0] s = 4'h1;
        logic [3:0] m = 4'h0;
        for (int i = 0; i < n; i++) begin
            pats.push_back(s);
            s = {s[2:0], s[3] ^ s[2]};
        end
        foreach (pats[i]) m = {m[2:0], m[3] ^ m[2]} ^ resp(md, pats[i]);
        return m;
    endfunction

    logic [3:0] seq [15];
    run_t       runs [4];
    int         edges;
    int         holds;
    logic [3:0] exp_sig;

    initial begin
        seq = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
        runs[0] = '{0, 4'h8, 4'h8, 1'b1};
        runs[1] = '{0, 4'h5, 4'h8, 1'b0};
        runs[2] = '{1, 4'h0, 4'h0, 1'b1};
        runs[3] = '{1, 4'h3, 4'h0, 1'b0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; hold = 1'b0; golden = 4'h8; mode = 0;
        for (int i = 0; i < 16; i++) cut_tab[i] = 4'h0;

        // Reset values
        #3;
        check("rst_cut_in", 32'(cut_in), 32'h1);
        check("rst_sig", 32'(signature), 32'h0);
        check("rst_pat_idx", 32'(pat_idx), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_pass", 32'(pass), 32'h0);
        check("rst_seed0_cut_in", 32'(cut_in2), 32'h1);
        #4 rst = 1'b0;
        step();

        // LFSR sequence, done latency, start-while-busy ignored, short PAT_CNT instance
        pulse_start();
        for (int k = 0; k < 15; k++) begin
            check($sformatf("seq_cut_in[%0d]", k), 32'(cut_in), 32'(seq[k]));
            check($sformatf("seq_pat_idx[%0d]", k), 32'(pat_idx), 32'(k));
            check($sformatf("seq_busy[%0d]", k), 32'(busy), 32'h1);
            check($sformatf("seq_done[%0d]", k), 32'(done), 32'h0);
            check($sformatf("short_done[%0d]", k), 32'(done2), 32'(k >= 14));
            start = (k == 7);
            step();
        end
        start = 1'b0;
        check("seq_done_end", 32'(done), 32'h1);
        check("seq_busy_end", 32'(busy), 32'h0);
        check("seq_pat_idx_end", 32'(pat_idx), 32'd15);
        check("loop_sig", 32'(signature), 32'h8);
        check("loop_pass", 32'(pass), 32'h1);
        check("short_sig", 32'(signature2), 32'h0);
        check("short_pass", 32'(pass2), 32'h0);
        check("short_pat_idx", 32'(pat_idx2), 32'd14);

        // Restart from DONE reproduces the result
        pulse_start();
        check("restart_done_drop", 32'(done), 32'h0);
        check("restart_busy", 32'(busy), 32'h1);
        check("restart_cut_in", 32'(cut_in), 32'h1);
        check("restart_pat_idx", 32'(pat_idx), 32'h0);
        wait_done(edges);
        check("restart_edges", 32'(edges), 32'd15);
        check("restart_sig", 32'(signature), 32'h8);
        check("restart_pass", 32'(pass), 32'h1);

        // Table of loopback / stuck-at runs
        for (int r = 0; r < 4; r++) begin
            mode = runs[r].md;
            golden = runs[r].gold;
            pulse_start();
            wait_done(edges);
            check($sformatf("tab_edges[%0d]", r), 32'(edges), 32'd15);
            check($sformatf("tab_sig[%0d]", r), 32'(signature), 32'(runs[r].exp_sig));
            check($sformatf("tab_pass[%0d]", r), 32'(pass), 32'(runs[r].exp_pass));
        end

        // Hold for 3 cycles at pat_idx 5
        mode = 0; golden = 4'h8;
        pulse_start();
        for (int i = 0; i < 5; i++) step();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold_cut_in[%0d]", i), 32'(cut_in), 32'(seq[5]));
            check($sformatf("hold_pat_idx[%0d]", i), 32'(pat_idx), 32'd5);
            check($sformatf("hold_sig[%0d]", i), 32'(signature), 32'(model_sig(5, 0)));
            check($sformatf("hold_busy[%0d]", i), 32'(busy), 32'h1);
        end
        hold = 1'b0;
        wait_done(edges);
        check("hold_edges", 32'(edges + 8), 32'd18);
        check("hold_sig", 32'(signature), 32'h8);
        check("hold_pass", 32'(pass), 32'h1);

        // Abort at pat_idx 7
        pulse_start();
        for (int i = 0; i < 7; i++) step();
        check("abort_pre_idx", 32'(pat_idx), 32'd7);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_cut_in", 32'(cut_in), 32'h1);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        check("abort_pass", 32'(pass), 32'h0);
        check("abort_pat_idx", 32'(pat_idx), 32'h0);
        check("abort_sig", 32'(signature), 32'h0);
        abort = 1'b1; start = 1'b1;
        step();
        abort = 1'b0; start = 1'b0;
        check("abort_over_start", 32'(busy), 32'h0);

        // Asynchronous reset mid-run
        pulse_start();
        for (int i = 0; i < 5; i++) step();
        #2 rst = 1'b1;
        #1;
        check("arst_cut_in", 32'(cut_in), 32'h1);
        check("arst_sig", 32'(signature), 32'h0);
        check("arst_pat_idx", 32'(pat_idx), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_done", 32'(done), 32'h0);
        #1 rst = 1'b0;
        step();
        check("arst_stays_idle", 32'(busy), 32'h0);

        // Random CUT tables, goldens and holds against the reference model
        mode = 2;
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 16; i++) cut_tab[i] = 4'($urandom);
            exp_sig = model_sig(15, 2);
            golden = ($urandom_range(0, 1) == 1) ? exp_sig : 4'($urandom);
            pulse_start();
            edges = 0;
            holds = 0;
            while (!done && edges < 100) begin
                hold = ($urandom_range(0, 3) == 0);
                if (hold) holds++;
                step();
                edges++;
            end
            hold = 1'b0;
            check($sformatf("rnd_done[%0d]", r), 32'(done), 32'h1);
            check($sformatf("rnd_edges[%0d]", r), 32'(edges), 32'(15 + holds));
            check($sformatf("rnd_sig[%0d]", r), 32'(signature), 32'(exp_sig));
            check($sformatf("rnd_pass[%0d]", r), 32'(pass), 32'(golden == exp_sig));
            check($sformatf("rnd_pat_idx[%0d]", r), 32'(pat_idx), 32'd15);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
